poker_card_dealer: RTL and testbench

- Upstream stage of the poker game core.
- On Start, deals 9 distinct cards from a 52-card deck: 2 hole cards per player and 5 community cards.
- Uses a free-running LFSR with rejection sampling, so the deal depends on how long the player waits before pressing Start.
- Holds the dealt hand stable for the core and the SSD mux. Uses the same Start/Done/Ack handshake as the core.

---
 rtl/poker_card_dealer.sv | 148 ++++++++++++++
 tb/tb_poker_card_dealer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poker_card_dealer.sv
// rtl/poker_card_dealer.sv - deals 9 distinct cards from a 52-card deck using a free-running LFSR
//
// Deals 2 hole cards per player plus 5 community cards. One candidate is drawn
// from the LFSR per clock in DEAL, and rejection sampling discards bad ranks and
// cards already dealt. The dealt hand is held stable until the next Start.
//
// Optional feature: define DEALER_SINGLE_STEP_EN to add the SCEN input. With it,
// candidates are evaluated only on clocks where SCEN=1.
//
// Ports:
//   Clk            system clock
//   Reset          asynchronous active-low reset
//   Start          begin a deal (sampled in IDLE)
//   Ack            acknowledge Done (sampled in DONE)
//   SCEN           single-step enable pulse (DEALER_SINGLE_STEP_EN only)
//   player*card*   hole-card ranks 1..13
//   card1..card5   community-card ranks 1..13
//   suits          suit of slot k at bits [2k+1:2k], in dealing order
//   Qi, Qd, Qc     one-hot state: IDLE, DEAL, DONE
//   Done           equals Qc
module poker_card_dealer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          NUM_SLOTS = 9
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Ack,
`ifdef DEALER_SINGLE_STEP_EN
  input  logic        SCEN,
`endif
  output logic [3:0]  player1card1,
  output logic [3:0]  player1card2,
  output logic [3:0]  player2card1,
  output logic [3:0]  player2card2,
  output logic [3:0]  card1,
  output logic [3:0]  card2,
  output logic [3:0]  card3,
  output logic [3:0]  card4,
  output logic [3:0]  card5,
  output logic [17:0] suits,
  output logic        Qi,
  output logic        Qd,
  output logic        Qc,
  output logic        Done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_DEAL = 3'b010,
    S_DONE = 3'b100
  } state_t;

  localparam logic [3:0] LAST_SLOT = 4'(NUM_SLOTS - 1);

  state_t       state_q;
  logic [15:0]  lfsr_q;
  logic [15:0]  lfsr_d;
  logic [63:0]  used_q;
  logic [3:0]   slot_q;
  logic [3:0]   rank_q [NUM_SLOTS];
  logic [17:0]  suits_q;

  logic         lfsr_fb;
  logic [3:0]   cand_rank;
  logic [1:0]   cand_suit;
  logic [5:0]   cand_idx;
  logic         cand_valid;
  logic         step_en;

  // Fibonacci feedback for taps 16,14,13,11: maximal length, so the low six
  // bits eventually visit every card index and a deal always finishes.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d  = {lfsr_q[14:0], lfsr_fb};

  assign cand_rank  = lfsr_q[3:0];
  assign cand_suit  = lfsr_q[5:4];
  assign cand_idx   = lfsr_q[5:0];
  assign cand_valid = (cand_rank != 4'd0) && (cand_rank <= 4'd13) && !used_q[cand_idx];

`ifdef DEALER_SINGLE_STEP_EN
  assign step_en = SCEN;
`else
  assign step_en = 1'b1;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      used_q  <= '0;
      slot_q  <= '0;
      suits_q <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        rank_q[k] <= '0;
      end
    end else begin
      // The LFSR runs in every state so the hand depends on Start timing.
      lfsr_q <= lfsr_d;
      case (state_q)
        S_IDLE: begin
          // Previous hand stays on the outputs until slots are overwritten.
          if (Start) begin
            used_q  <= '0;
            slot_q  <= '0;
            state_q <= S_DEAL;
          end
        end
        S_DEAL: begin
          if (step_en && cand_valid) begin
            rank_q[slot_q]             <= cand_rank;
            suits_q[{slot_q, 1'b0} +: 2] <= cand_suit;
            used_q[cand_idx]           <= 1'b1;
            if (slot_q == LAST_SLOT) begin
              state_q <= S_DONE;
            end else begin
              slot_q <= slot_q + 4'd1;
            end
          end
        end
        S_DONE: begin
          if (Ack) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Dealing order alternates hole cards between players, then the board.
  assign player1card1 = rank_q[0];
  assign player2card1 = rank_q[1];
  assign player1card2 = rank_q[2];
  assign player2card2 = rank_q[3];
  assign card1        = rank_q[4];
  assign card2        = rank_q[5];
  assign card3        = rank_q[6];
  assign card4        = rank_q[7];
  assign card5        = rank_q[8];
  assign suits        = suits_q;

  assign Qi   = state_q[0];
  assign Qd   = state_q[1];
  assign Qc   = state_q[2];
  assign Done = state_q[2];

endmodule

// File: tb/tb_poker_card_dealer.sv
// tb/tb_poker_card_dealer.sv - directed self-checking bench for poker_card_dealer
module tb_poker_card_dealer;

  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          BOUND = 5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ack = 1'b0;
`ifdef DEALER_SINGLE_STEP_EN
  logic        scen = 1'b0;
`endif
  logic [3:0]  p1c1, p1c2, p2c1, p2c2, c1, c2, c3, c4, c5;
  logic [17:0] suits;
  logic        qi, qd, qc, done;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  logic [3:0]  got_r [9];
  logic [1:0]  got_s [9];
  logic [3:0]  exp_r [9];
  logic [1:0]  exp_s [9];
  logic [3:0]  prev_r [9];
  logic [1:0]  prev_s [9];
  int          exp_n;

  poker_card_dealer #(.LFSR_SEED(SEED), .NUM_SLOTS(9)) dut (
    .Clk(clk),
    .Reset(rst_n),
    .Start(start),
    .Ack(ack),
`ifdef DEALER_SINGLE_STEP_EN
    .SCEN(scen),
`endif
    .player1card1(p1c1),
    .player1card2(p1c2),
    .player2card1(p2c1),
    .player2card2(p2c2),
    .card1(c1),
    .card2(c2),
    .card3(c3),
    .card4(c4),
    .card5(c5),
    .suits(suits),
    .Qi(qi),
    .Qd(qd),
    .Qc(qc),
    .Done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference LFSR, reset and clocked alongside the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic get_hand();
    got_r[0] = p1c1; got_r[1] = p2c1; got_r[2] = p1c2; got_r[3] = p2c2;
    got_r[4] = c1;   got_r[5] = c2;   got_r[6] = c3;   got_r[7] = c4;
    got_r[8] = c5;
    for (int k = 0; k < 9; k++) got_s[k] = suits[2*k +: 2];
  endtask

  // Expected hand when Start is sampled with the LFSR holding l0: the first
  // candidate is the value after that edge; exp_n counts DEAL clocks.
  task automatic predict(input logic [15:0] l0);
    logic [15:0] l;
    logic [63:0] u;
    int slot;
    l = lfsr_step(l0);
    u = '0;
    slot = 0;
    exp_n = 0;
    while (slot < 9 && exp_n < BOUND) begin
      exp_n++;
      if (l[3:0] >= 4'd1 && l[3:0] <= 4'd13 && !u[l[5:0]]) begin
        exp_r[slot] = l[3:0];
        exp_s[slot] = l[5:4];
        u[l[5:0]] = 1'b1;
        slot++;
      end
      l = lfsr_step(l);
    end
  endtask

  task automatic save_prev();
    get_hand();
    for (int k = 0; k < 9; k++) begin
      prev_r[k] = got_r[k];
      prev_s[k] = got_s[k];
    end
  endtask

  // Start on the next edge, then wait for Done and compare latency and hand.
  task automatic run_deal(input string name, input bit start_in_deal, input bit with_ack);
    int n;
    start = 1'b1;
    ack = with_ack;
    predict(m_lfsr);
    tick();
    start = 1'b0;
    ack = 1'b0;
    checks++;
    if (qd !== 1'b1 || qi !== 1'b0) begin
      errors++;
      $display("FAIL %s_enter_deal got Qi=%b Qd=%b exp Qi=0 Qd=1", name, qi, qd);
    end
    n = 0;
    if (start_in_deal) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
    end
    while (done !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
    checks++;
    if (n !== exp_n || done !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency got %0d clocks done=%b exp %0d clocks", name, n, done, exp_n);
    end
    get_hand();
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (got_r[k] !== exp_r[k] || got_s[k] !== exp_s[k]) begin
        errors++;
        $display("FAIL %s_slot%0d got rank %0d suit %0d exp rank %0d suit %0d",
                 name, k, got_r[k], got_s[k], exp_r[k], exp_s[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    checks++;
    if (m_lfsr !== SEED) begin
      errors++;
      $display("FAIL reset_model_lfsr got %h exp %h", m_lfsr, SEED);
    end
    get_hand();
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (got_r[k] !== 4'd0) begin
        errors++;
        $display("FAIL reset_rank%0d got %0d exp 0", k, got_r[k]);
      end
    end
    checks++;
    if (suits !== 18'd0 || qi !== 1'b1 || qd !== 1'b0 || qc !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got suits=%h Qi=%b Qd=%b Qc=%b Done=%b exp 0 1 0 0 0",
               suits, qi, qd, qc, done);
    end
  endtask

  task automatic test_first_deal();
    bit distinct;
    bit in_range;
    repeat (4) tick();
    run_deal("deal1", 1'b0, 1'b0);
    distinct = 1'b1;
    in_range = 1'b1;
    for (int a = 0; a < 9; a++) begin
      if (got_r[a] < 4'd1 || got_r[a] > 4'd13) in_range = 1'b0;
      for (int b = a + 1; b < 9; b++)
        if (got_r[a] == got_r[b] && got_s[a] == got_s[b]) distinct = 1'b0;
    end
    checks++;
    if (!distinct || !in_range) begin
      errors++;
      $display("FAIL deal1_distinct_range got distinct=%b in_range=%b exp 1 1", distinct, in_range);
    end
    save_prev();
  endtask

  task automatic test_done_hold();
    start = 1'b1;
    tick();
    start = 1'b0;
    get_hand();
    checks++;
    if (qc !== 1'b1 || got_r[0] !== prev_r[0] || got_r[8] !== prev_r[8] || got_s[4] !== prev_s[4]) begin
      errors++;
      $display("FAIL start_in_done got Qc=%b r0=%0d r8=%0d exp Qc=1 r0=%0d r8=%0d",
               qc, got_r[0], got_r[8], prev_r[0], prev_r[8]);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (qi !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL ack_to_idle got Qi=%b Done=%b exp 1 0", qi, done);
    end
    for (int c = 0; c < 20; c++) begin
      ack = (c == 5 || c == 6);
      tick();
      get_hand();
      checks++;
      if (qi !== 1'b1 || got_r !== prev_r || got_s !== prev_s) begin
        errors++;
        $display("FAIL idle_hold_c%0d got Qi=%b r0=%0d s0=%0d exp Qi=1 r0=%0d s0=%0d",
                 c, qi, got_r[0], got_s[0], prev_r[0], prev_s[0]);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_second_deal();
    bit differs;
    run_deal("deal2", 1'b1, 1'b1);
    differs = 1'b0;
    for (int k = 0; k < 9; k++)
      if (got_r[k] !== prev_r[k] || got_s[k] !== prev_s[k]) differs = 1'b1;
    checks++;
    if (!differs) begin
      errors++;
      $display("FAIL deal2_new_hand got same hand as deal1 exp different");
    end
    save_prev();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset_mid_deal();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    get_hand();
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (got_r[k] !== 4'd0) begin
        errors++;
        $display("FAIL midreset_rank%0d got %0d exp 0", k, got_r[k]);
      end
    end
    checks++;
    if (suits !== 18'd0 || qi !== 1'b1 || qd !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state got suits=%h Qi=%b Qd=%b Done=%b exp 0 1 0 0", suits, qi, qd, done);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_deal_after_reset();
    repeat (4) tick();
    run_deal("deal3", 1'b0, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    save_prev();
  endtask

`ifdef DEALER_SINGLE_STEP_EN
  task automatic test_single_step();
    logic [63:0] u;
    int slot;
    int n;
    scen = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    get_hand();
    checks++;
    if (qd !== 1'b1 || got_r !== prev_r || got_s !== prev_s) begin
      errors++;
      $display("FAIL step_hold got Qd=%b r0=%0d exp Qd=1 r0=%0d", qd, got_r[0], prev_r[0]);
    end
    u = '0;
    slot = 0;
    n = 0;
    while (slot < 9 && n < BOUND) begin
      if (m_lfsr[3:0] >= 4'd1 && m_lfsr[3:0] <= 4'd13 && !u[m_lfsr[5:0]]) begin
        exp_r[slot] = m_lfsr[3:0];
        exp_s[slot] = m_lfsr[5:4];
        u[m_lfsr[5:0]] = 1'b1;
        slot++;
        scen = 1'b1;
      end else begin
        scen = 1'b0;
      end
      tick();
      n++;
    end
    scen = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL step_done got Done=%b exp 1", done);
    end
    get_hand();
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (got_r[k] !== exp_r[k] || got_s[k] !== exp_s[k]) begin
        errors++;
        $display("FAIL step_slot%0d got rank %0d suit %0d exp rank %0d suit %0d",
                 k, got_r[k], got_s[k], exp_r[k], exp_s[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_deal();
    test_done_hold();
    test_second_deal();
    test_reset_mid_deal();
    test_deal_after_reset();
`ifdef DEALER_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
